// File: rtl/typed_stream_arbiter.sv
// Packet-granular round-robin arbiter that shares one typed ndata datapath
// (type descriptor stream plus ndata stream) among NUM_REQ requesters.
module typed_stream_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int NUM_ELEMENTS = 8,
    parameter int DATA_WIDTH   = 64,
    parameter int TYPE_WIDTH   = 8,
    localparam int GRANT_W     = $clog2(NUM_REQ),
    localparam int BEAT_W      = NUM_ELEMENTS * DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic [NUM_REQ-1:0]            req_type_valid,
    input  logic [NUM_REQ*TYPE_WIDTH-1:0] req_type_data,
    output logic [NUM_REQ-1:0]            req_type_ready,

    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*BEAT_W-1:0]     req_data,
    input  logic [NUM_REQ*NUM_ELEMENTS-1:0] req_keep,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,

    output logic                          out_type_valid,
    output logic [TYPE_WIDTH-1:0]         out_type_data,
    input  logic                          out_type_ready,

    output logic                          out_valid,
    output logic [BEAT_W-1:0]             out_data,
    output logic [NUM_ELEMENTS-1:0]       out_keep,
    output logic                          out_last,
    input  logic                          out_ready,

    output logic [GRANT_W-1:0]            grant_id,
    output logic                          busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [GRANT_W-1:0]   grant_q, grant_d;
    logic [GRANT_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic                 type_done_q, type_done_d;
    logic                 data_done_q, data_done_d;

    logic                 locked;
    logic                 found;
    logic [GRANT_W-1:0]   winner;
    int                   arb_idx;
    logic                 type_hs;
    logic                 last_hs;
    logic                 release_pkt;

    logic [TYPE_WIDTH-1:0]   type_arr [NUM_REQ];
    logic [BEAT_W-1:0]       data_arr [NUM_REQ];
    logic [NUM_ELEMENTS-1:0] keep_arr [NUM_REQ];

    genvar gi;
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign type_arr[gi] = req_type_data[gi*TYPE_WIDTH +: TYPE_WIDTH];
        assign data_arr[gi] = req_data[gi*BEAT_W +: BEAT_W];
        assign keep_arr[gi] = req_keep[gi*NUM_ELEMENTS +: NUM_ELEMENTS];
    end

    assign locked   = (state_q == LOCKED);
    assign busy     = locked;
    assign grant_id = grant_q;

    // Round-robin search: first descriptor-valid requester at or after rr_ptr.
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        arb_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            arb_idx = int'(rr_ptr_q) + k;
            if (arb_idx >= NUM_REQ) begin
                arb_idx = arb_idx - NUM_REQ;
            end
            if (!found && req_type_valid[GRANT_W'(arb_idx)]) begin
                found  = 1'b1;
                winner = GRANT_W'(arb_idx);
            end
        end
    end

    // Pass-through mux; each stream is shut off once its handshake is done
    // so a descriptor is never re-sent and the next packet never leaks.
    always_comb begin
        out_type_valid = 1'b0;
        out_type_data  = '0;
        out_valid      = 1'b0;
        out_data       = '0;
        out_keep       = '0;
        out_last       = 1'b0;
        req_type_ready = '0;
        req_ready      = '0;
        if (locked) begin
            out_type_valid = req_type_valid[grant_q] && !type_done_q;
            out_type_data  = type_arr[grant_q];
            out_valid      = req_valid[grant_q] && !data_done_q;
            out_data       = data_arr[grant_q];
            out_keep       = keep_arr[grant_q];
            out_last       = req_last[grant_q];
            req_type_ready[grant_q] = out_type_ready && !type_done_q;
            req_ready[grant_q]      = out_ready && !data_done_q;
        end
    end

    assign type_hs     = out_type_valid && out_type_ready;
    assign last_hs     = out_valid && out_ready && out_last;
    assign release_pkt = locked && (type_done_q || type_hs) && (data_done_q || last_hs);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        type_done_d = type_done_q;
        data_done_d = data_done_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d     = LOCKED;
                    grant_d     = winner;
                    type_done_d = 1'b0;
                    data_done_d = 1'b0;
                end
            end
            LOCKED: begin
                type_done_d = type_done_q || type_hs;
                data_done_d = data_done_q || last_hs;
                if (release_pkt) begin
                    state_d     = IDLE;
                    rr_ptr_d    = (grant_q == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                    type_done_d = 1'b0;
                    data_done_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            type_done_q <= 1'b0;
            data_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            type_done_q <= type_done_d;
            data_done_q <= data_done_d;
        end
    end

endmodule

// File: tb/tb_typed_stream_arbiter.sv
// Directed bench for typed_stream_arbiter: arbitration order, pass-through,
// split handshakes, leak guard, backpressure and mid-packet reset.
module tb_typed_stream_arbiter;

    localparam int NR = 4;
    localparam int NE = 8;
    localparam int DW = 64;
    localparam int TW = 8;
    localparam int BW = NE * DW;
    localparam int GW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_type_valid, req_type_ready, req_valid, req_last, req_ready;
    logic [NR*TW-1:0]  req_type_data;
    logic [NR*BW-1:0]  req_data;
    logic [NR*NE-1:0]  req_keep;
    logic              out_type_valid, out_type_ready, out_valid, out_last, out_ready;
    logic [TW-1:0]     out_type_data;
    logic [BW-1:0]     out_data;
    logic [NE-1:0]     out_keep;
    logic [GW-1:0]     grant_id;
    logic              busy;

    logic [TW-1:0]     td_a [NR];
    logic [BW-1:0]     d_a  [NR];
    logic [NE-1:0]     k_a  [NR];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_type_data = '0;
        req_data      = '0;
        req_keep      = '0;
        for (int i = 0; i < NR; i++) begin
            req_type_data[i*TW +: TW] = td_a[i];
            req_data[i*BW +: BW]      = d_a[i];
            req_keep[i*NE +: NE]      = k_a[i];
        end
    end

    typed_stream_arbiter #(
        .NUM_REQ(NR), .NUM_ELEMENTS(NE), .DATA_WIDTH(DW), .TYPE_WIDTH(TW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_type_valid(req_type_valid), .req_type_data(req_type_data), .req_type_ready(req_type_ready),
        .req_valid(req_valid), .req_data(req_data), .req_keep(req_keep), .req_last(req_last),
        .req_ready(req_ready),
        .out_type_valid(out_type_valid), .out_type_data(out_type_data), .out_type_ready(out_type_ready),
        .out_valid(out_valid), .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
        .out_ready(out_ready),
        .grant_id(grant_id), .busy(busy)
    );

    function automatic logic [BW-1:0] mk_beat(input int r, input int b);
        logic [BW-1:0] v;
        for (int e = 0; e < NE; e++) v[e*DW +: DW] = {16'(r), 16'(b), 16'(e), 16'h5A5A};
        return v;
    endfunction

    function automatic logic [NE-1:0] keepf(input int b);
        return NE'((1 << b) | 128);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic set_req(input logic [GW-1:0] r, input logic tv, input logic [TW-1:0] td,
                           input logic v, input int b, input logic l);
        req_type_valid[r] = tv;
        td_a[r]           = td;
        req_valid[r]      = v;
        d_a[r]            = mk_beat(int'(r), b);
        k_a[r]            = keepf(b);
        req_last[r]       = l;
    endtask

    task automatic clear_all;
        req_type_valid = '0;
        req_valid      = '0;
        req_last       = '0;
        for (int i = 0; i < NR; i++) begin
            td_a[i] = '0;
            d_a[i]  = '0;
            k_a[i]  = '0;
        end
        out_ready      = 1'b0;
        out_type_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        settle;
        total++;
        if ({busy, grant_id, out_valid, out_type_valid, req_ready, req_type_ready} !== '0)
            $display("FAIL reset_ctrl: got busy=%b grant=%0d ov=%b otv=%b rr=%b rtr=%b, want all 0",
                     busy, grant_id, out_valid, out_type_valid, req_ready, req_type_ready);
        else passed++;
        total++;
        if ({out_data, out_keep, out_type_data, out_last} !== '0)
            $display("FAIL reset_data: got keep=%h type=%h, want 0", out_keep, out_type_data);
        else passed++;
    endtask

    task automatic test_single;
        set_req(2'd2, 1'b1, 8'h20, 1'b1, 0, 1'b0);
        out_ready = 1'b1;
        out_type_ready = 1'b0;
        settle;
        total++;
        if ({busy, out_valid, out_type_valid, req_ready, out_type_data} !== '0)
            $display("FAIL single_idle: got busy=%b ov=%b rr=%b type=%h, want 0", busy, out_valid, req_ready, out_type_data);
        else passed++;
        tick;
        for (int b = 0; b < 3; b++) begin
            set_req(2'd2, 1'b1, 8'h20, 1'b1, b, b == 2);
            out_type_ready = (b == 2);
            settle;
            total++;
            if ({busy, grant_id, req_ready} !== {1'b1, 2'd2, 4'b0100})
                $display("FAIL single_grant b%0d: got busy=%b grant=%0d rr=%b, want 1/2/0100", b, busy, grant_id, req_ready);
            else passed++;
            total++;
            if ({out_valid, out_last, out_keep} !== {1'b1, b == 2, keepf(b)} || out_data !== mk_beat(2, b))
                $display("FAIL single_beat b%0d: got v=%b l=%b keep=%h, want 1/%0d/%h", b, out_valid, out_last, out_keep, b == 2, keepf(b));
            else passed++;
            total++;
            if ({out_type_valid, out_type_data, req_type_ready} !== {1'b1, 8'h20, (b == 2) ? 4'b0100 : 4'b0000})
                $display("FAIL single_type b%0d: got tv=%b td=%h rtr=%b", b, out_type_valid, out_type_data, req_type_ready);
            else passed++;
            tick;
        end
        clear_all;
        settle;
        total++;
        if (busy !== 1'b0) $display("FAIL single_release: got busy=%b, want 0", busy);
        else passed++;
        set_req(2'd0, 1'b1, 8'h01, 1'b1, 0, 1'b1);
        set_req(2'd3, 1'b1, 8'h03, 1'b1, 0, 1'b1);
        out_ready = 1'b1;
        out_type_ready = 1'b1;
        tick;
        settle;
        total++;
        if ({busy, grant_id} !== {1'b1, 2'd3} || out_data !== mk_beat(3, 0))
            $display("FAIL single_rrptr: got busy=%b grant=%0d, want 1/3", busy, grant_id);
        else passed++;
        tick;
        clear_all;
    endtask

    task automatic test_fairness;
        for (int r = 0; r < NR; r++) set_req(GW'(r), 1'b1, 8'(8'h40 + r), 1'b1, 0, 1'b1);
        out_ready = 1'b1;
        out_type_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick;
            settle;
            total++;
            if ({busy, grant_id, req_ready} !== {1'b1, GW'(n % 4), 4'(1 << (n % 4))}
                || out_data !== mk_beat(n % 4, 0) || out_type_data !== 8'(8'h40 + n % 4))
                $display("FAIL fair_grant n%0d: got busy=%b grant=%0d rr=%b, want 1/%0d", n, busy, grant_id, req_ready, n % 4);
            else passed++;
            tick;
            settle;
            total++;
            if ({busy, out_valid, req_ready} !== '0)
                $display("FAIL fair_idle n%0d: got busy=%b ov=%b rr=%b, want 0", n, busy, out_valid, req_ready);
            else passed++;
            if (n == 5) clear_all;
        end
    endtask

    task automatic test_split;
        set_req(2'd1, 1'b1, 8'h51, 1'b1, 0, 1'b1);
        out_type_ready = 1'b1;
        out_ready = 1'b0;
        tick;
        settle;
        total++;
        if ({grant_id, out_type_valid, req_type_ready, req_ready, out_valid} !== {2'd1, 1'b1, 4'b0010, 4'b0000, 1'b1})
            $display("FAIL split_c1: got grant=%0d tv=%b rtr=%b rr=%b", grant_id, out_type_valid, req_type_ready, req_ready);
        else passed++;
        tick;
        for (int c = 2; c < 5; c++) begin
            settle;
            total++;
            if ({busy, out_type_valid, req_type_ready, out_valid} !== {1'b1, 1'b0, 4'b0000, 1'b1})
                $display("FAIL split_type_off c%0d: got busy=%b tv=%b rtr=%b ov=%b", c, busy, out_type_valid, req_type_ready, out_valid);
            else passed++;
            tick;
        end
        out_ready = 1'b1;
        settle;
        total++;
        if ({req_ready, out_last} !== {4'b0010, 1'b1})
            $display("FAIL split_c5: got rr=%b last=%b, want 0010/1", req_ready, out_last);
        else passed++;
        tick;
        settle;
        total++;
        if (busy !== 1'b0) $display("FAIL split_release1: got busy=%b, want 0", busy);
        else passed++;
        clear_all;

        set_req(2'd2, 1'b1, 8'h52, 1'b1, 0, 1'b1);
        out_ready = 1'b1;
        out_type_ready = 1'b0;
        tick;
        settle;
        total++;
        if ({grant_id, out_valid, req_ready, out_type_valid} !== {2'd2, 1'b1, 4'b0100, 1'b1})
            $display("FAIL split2_c1: got grant=%0d ov=%b rr=%b tv=%b", grant_id, out_valid, req_ready, out_type_valid);
        else passed++;
        tick;
        for (int c = 2; c < 4; c++) begin
            settle;
            total++;
            if ({busy, out_valid, req_ready, out_type_valid} !== {1'b1, 1'b0, 4'b0000, 1'b1})
                $display("FAIL split2_data_off c%0d: got busy=%b ov=%b rr=%b tv=%b", c, busy, out_valid, req_ready, out_type_valid);
            else passed++;
            tick;
        end
        out_type_ready = 1'b1;
        settle;
        total++;
        if (req_type_ready !== 4'b0100) $display("FAIL split2_c4: got rtr=%b, want 0100", req_type_ready);
        else passed++;
        tick;
        settle;
        total++;
        if (busy !== 1'b0) $display("FAIL split_release2: got busy=%b, want 0", busy);
        else passed++;
        clear_all;
    endtask

    task automatic test_leak;
        set_req(2'd1, 1'b1, 8'h11, 1'b1, 0, 1'b1);
        out_ready = 1'b1;
        out_type_ready = 1'b0;
        tick;
        settle;
        total++;
        if ({grant_id, out_valid, req_ready} !== {2'd1, 1'b1, 4'b0010})
            $display("FAIL leak_c1: got grant=%0d ov=%b rr=%b", grant_id, out_valid, req_ready);
        else passed++;
        tick;
        set_req(2'd1, 1'b1, 8'h11, 1'b1, 1, 1'b0);
        out_type_ready = 1'b1;
        settle;
        total++;
        if ({busy, out_valid, req_ready, out_type_valid} !== {1'b1, 1'b0, 4'b0000, 1'b1})
            $display("FAIL leak_guard: got busy=%b ov=%b rr=%b tv=%b", busy, out_valid, req_ready, out_type_valid);
        else passed++;
        tick;
        set_req(2'd1, 1'b1, 8'h12, 1'b1, 1, 1'b0);
        settle;
        total++;
        if ({busy, out_valid, req_ready} !== '0)
            $display("FAIL leak_idle: got busy=%b ov=%b rr=%b, want 0", busy, out_valid, req_ready);
        else passed++;
        tick;
        settle;
        total++;
        if ({busy, grant_id, out_valid, out_type_data} !== {1'b1, 2'd1, 1'b1, 8'h12} || out_data !== mk_beat(1, 1))
            $display("FAIL leak_regrant: got busy=%b grant=%0d ov=%b td=%h", busy, grant_id, out_valid, out_type_data);
        else passed++;
        set_req(2'd1, 1'b1, 8'h12, 1'b1, 1, 1'b1);
        tick;
        clear_all;
    endtask

    task automatic test_backpressure;
        int b = 0;
        int exp_b = 0;
        int acc = 0;
        set_req(2'd0, 1'b1, 8'h30, 1'b1, 0, 1'b0);
        out_type_ready = 1'b1;
        tick;
        for (int c = 0; c < 7; c++) begin
            out_ready = (c % 2 == 0);
            set_req(2'd0, 1'b1, 8'h30, 1'b1, b, b == 3);
            settle;
            total++;
            if (out_data !== mk_beat(0, exp_b) || out_keep !== keepf(exp_b) || out_valid !== 1'b1)
                $display("FAIL bp_beat c%0d: got keep=%h v=%b, want keep=%h (beat %0d)", c, out_keep, out_valid, keepf(exp_b), exp_b);
            else passed++;
            if (out_valid && out_ready) acc++;
            if (req_ready[0] && req_valid[0] && b < 3) b++;
            if (c % 2 == 0) exp_b++;
            tick;
        end
        settle;
        total++;
        if (busy !== 1'b0 || acc !== 4)
            $display("FAIL bp_end: got busy=%b accepted=%0d, want 0/4", busy, acc);
        else passed++;
        clear_all;
    endtask

    task automatic test_mid_reset;
        set_req(2'd2, 1'b1, 8'h40, 1'b1, 0, 1'b0);
        out_ready = 1'b1;
        tick;
        settle;
        total++;
        if ({busy, grant_id} !== {1'b1, 2'd2}) $display("FAIL mrst_grant: got busy=%b grant=%0d, want 1/2", busy, grant_id);
        else passed++;
        tick;
        set_req(2'd2, 1'b1, 8'h40, 1'b1, 1, 1'b0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        set_req(2'd0, 1'b1, 8'h41, 1'b1, 0, 1'b1);
        set_req(2'd2, 1'b1, 8'h40, 1'b1, 0, 1'b0);
        settle;
        total++;
        if ({busy, grant_id, out_valid, out_type_valid, req_ready, req_type_ready} !== '0 || out_data !== '0)
            $display("FAIL mrst_state: got busy=%b grant=%0d ov=%b tv=%b rr=%b rtr=%b, want 0",
                     busy, grant_id, out_valid, out_type_valid, req_ready, req_type_ready);
        else passed++;
        tick;
        settle;
        total++;
        if ({busy, grant_id} !== {1'b1, 2'd0}) $display("FAIL mrst_regrant: got busy=%b grant=%0d, want 1/0", busy, grant_id);
        else passed++;
        clear_all;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_all;
        rst = 1'b1;
        test_reset;
        test_single;
        test_fairness;
        test_split;
        test_leak;
        test_backpressure;
        test_mid_reset;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/typed_stream_arbiter.md
Name: typed_stream_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one typed ndata datapath among NUM_REQ requesters. The shared datapath is the ndata-to-AXI typed width adapter plus its type descriptor handshake.
- Each requester presents a type descriptor stream and an ndata stream. The arbiter locks a grant for one whole packet and muxes both streams to a single downstream pair.
- It releases the grant only after the type descriptor and the last data beat have both been accepted downstream.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- NUM_ELEMENTS, 8, elements per ndata beat.
- DATA_WIDTH, 64, bits per element.
- TYPE_WIDTH, 8, width of the type descriptor (type_t).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_type_valid  in  NUM_REQ  per-requester type descriptor valid.
- req_type_data  in  NUM_REQ*TYPE_WIDTH  per-requester type descriptor; requester i at bits [i*TYPE_WIDTH +: TYPE_WIDTH].
- req_type_ready  out  NUM_REQ  per-requester type descriptor ready.
- req_valid  in  NUM_REQ  per-requester data beat valid.
- req_data  in  NUM_REQ*NUM_ELEMENTS*DATA_WIDTH  per-requester data beat.
- req_keep  in  NUM_REQ*NUM_ELEMENTS  per-requester element keep.
- req_last  in  NUM_REQ  per-requester last beat of packet.
- req_ready  out  NUM_REQ  per-requester data ready.
- out_type_valid, out_type_data, out_type_ready  out/out/in  1/TYPE_WIDTH/1  type descriptor stream to the shared datapath.
- out_valid, out_data, out_keep, out_last, out_ready  out/out/out/out/in  1/NUM_ELEMENTS*DATA_WIDTH/NUM_ELEMENTS/1/1  ndata stream to the shared datapath.
- grant_id  out  $clog2(NUM_REQ)  index of the current grant; valid while busy.
- busy  out  1  a packet is granted.

Behaviour:
- States:
  - IDLE: no grant; all req_*_ready=0; out_valid=0; out_type_valid=0.
  - LOCKED: one requester is granted.
- Arbitration in IDLE:
  - Candidates are requesters with req_type_valid=1. req_valid is not considered.
  - The winner is the first candidate at or after rr_ptr, searching upward with wrap NUM_REQ-1 -> 0.
  - The winner is registered into grant_id and the state moves to LOCKED on the next edge. Arbitration latency is 1 cycle.
  - If there are no candidates, stay in IDLE.
- LOCKED, with g=grant_id:
  - Purely combinational pass-through: out_type_* and out_* mirror requester g.
  - req_type_ready[g]=out_type_ready and req_ready[g]=out_ready. All non-granted readies are 0.
  - Flag type_done is set on out_type_valid&&out_type_ready.
  - Flag data_done is set on out_valid&&out_ready&&out_last.
  - After type_done is set, out_type_valid is forced to 0 and req_type_ready[g]=0. A descriptor is never consumed twice.
  - After data_done is set, out_valid is forced to 0 and req_ready[g]=0. Beats of the next packet are never leaked.
- Release:
  - Triggered in the cycle where both conditions are met, counting events in the current cycle (i.e. registered flag OR the handshake this cycle).
  - Next edge: state=IDLE, rr_ptr=(g+1) mod NUM_REQ, both flags cleared.
  - Type and last-beat handshakes may occur in the same cycle or in either order.
  - There is a minimum of 1 IDLE cycle between packets.
- Packets carry ≥1 beat; zero-length packets are not supported.
- Data beats with out_last=0 never change state.
- Requester deassertion of valid while granted is permitted and simply stalls; the grant holds indefinitely.
- Reset (any cycle, including mid-packet):
  - state=IDLE, rr_ptr=0, grant_id=0, busy=0, flags=0.
  - All outputs valid/ready=0, out_data/out_keep/out_type_data=0.
  - A partially transferred packet is abandoned, and the requester must restart it.
- busy=1 exactly in LOCKED.
- Non-granted requester inputs have no effect on any output.

Test Plan:
- Single packet: req 2 type=0x20, 3 beats, last on beat 3, out ready always. Required response:
  - grant_id=2 one cycle after type valid.
  - 3 output beats identical to input.
  - type accepted with the last beat.
  - IDLE on the next cycle; rr_ptr=3.
- Fairness: all 4 requesters continuously valid, 1-beat packets. Required response:
  - Grant order 0,1,2,3,0,1.
  - Each grant is 2 cycles (LOCKED plus IDLE).
- Split handshakes: downstream accepts the type in cycle 1 and holds out_ready=0 until cycle 5. Required response:
  - out_type_valid=0 from cycle 2.
  - Release only after the last beat is handshaken.
  - Repeat with data last accepted first, then type 3 cycles later: release follows the type handshake.
- Leak guard: granted req 1 presents a second packet's beat immediately after last. Required response:
  - req_ready[1]=0 after data_done.
  - The next packet's beat appears only after re-arbitration.
- Backpressure: out_ready toggles 1010 over a 4-beat packet. Required response:
  - No beat is dropped or duplicated.
  - keep/data ordering is preserved.
- Mid-packet reset: rst pulsed 1 cycle during beat 2 of 4. Required response:
  - All valids/readies are 0 and busy=0 in the following cycle.
  - Next grant goes to requester 0 if it is valid.
